// File: rtl/axi_arb_pkg.sv
// Shared types and grant encodings for the two-master AXI channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Picks the one-hot winner from the request pair; prio=0 favours M0 on a tie.
  function automatic logic [1:0] pick_grant(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = GNT_NONE;
    case (req)
      2'b01:   g = GNT_M0;
      2'b10:   g = GNT_M1;
      2'b11:   g = prio ? GNT_M1 : GNT_M0;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ax_arbiter.sv
// Two-master round-robin arbiter for one AXI direction (write: AW/W/B, read: AR/R).
// Holds a one-hot grant from address acceptance until the burst (and the write
// response) completes, with an optional watchdog that forcibly releases a stuck grant.
module ax_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit IS_WRITE    = 1'b1,
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 16
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [1:0] axvalid_m,
  input  logic       axready_s,
  output logic [1:0] axready_m,
  output logic [1:0] gnt,
  input  logic       dvalid,
  input  logic       dready,
  input  logic       dlast,
  input  logic       bvalid,
  input  logic       bready,
  output logic       d_sel,
  output logic       busy,
  output logic       timeout
);

  // The watchdog fires during the cycle the counter reads TIMEOUT_CYC-1, so the
  // abort edge lands exactly TIMEOUT_CYC edges after DATA was entered.
  localparam bit WD_ON   = (TIMEOUT_CYC > 0);
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [TO_W-1:0] TO_LAST_W = TO_LAST[TO_W-1:0];
  localparam logic [TO_W-1:0] CNT_MAX   = {TO_W{1'b1}};

  arb_state_e      state, state_nxt;
  logic [1:0]      gnt_nxt;
  logic            prio, prio_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            timeout_nxt;

  logic addr_hs;
  logic last_hs;
  logic b_hs;
  logic wd_expire;

  assign axready_m = (state == ARB_ADDR) ? (gnt & {2{axready_s}}) : GNT_NONE;
  assign d_sel     = (state == ARB_DATA);
  assign busy      = (state != ARB_IDLE);

  assign addr_hs   = |(axvalid_m & axready_m);
  assign last_hs   = dvalid & dready & dlast;
  assign b_hs      = bvalid & bready;
  assign wd_expire = WD_ON && (cnt == TO_LAST_W);

  // Next-state logic: arbitration in IDLE, then walk the transaction phases;
  // every release (normal or watchdog) drops the grant and hands priority to the other master.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    prio_nxt    = prio;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;

    if (((state == ARB_DATA) || (state == ARB_RESP)) && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end

    case (state)
      ARB_IDLE: begin
        if (|axvalid_m) begin
          gnt_nxt   = pick_grant(axvalid_m, prio);
          state_nxt = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (addr_hs) begin
          state_nxt = ARB_DATA;
          cnt_nxt   = '0;
        end
      end
      ARB_DATA: begin
        if (last_hs) begin
          if (IS_WRITE) begin
            state_nxt = ARB_RESP;
          end else begin
            state_nxt = ARB_IDLE;
            gnt_nxt   = GNT_NONE;
            prio_nxt  = gnt[0];
          end
        end else if (wd_expire) begin
          state_nxt   = ARB_IDLE;
          gnt_nxt     = GNT_NONE;
          prio_nxt    = gnt[0];
          timeout_nxt = 1'b1;
        end
      end
      ARB_RESP: begin
        if (b_hs) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = GNT_NONE;
          prio_nxt  = gnt[0];
        end else if (wd_expire) begin
          state_nxt   = ARB_IDLE;
          gnt_nxt     = GNT_NONE;
          prio_nxt    = gnt[0];
          timeout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

  // Arbiter state registers, cleared asynchronously so the grant drops the instant reset asserts.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= ARB_IDLE;
      gnt     <= GNT_NONE;
      prio    <= 1'b0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      prio    <= prio_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_ax_arbiter.sv
// Directed self-checking bench for ax_arbiter: one write instance with a 16-cycle
// watchdog and one read instance without watchdog, sharing the same stimulus.
module tb_ax_arbiter;

  logic       ACLK;
  logic       ARESETn;
  logic [1:0] axvalid_m;
  logic       axready_s;
  logic       dvalid;
  logic       dready;
  logic       dlast;
  logic       bvalid;
  logic       bready;

  logic [1:0] w_axready_m, w_gnt;
  logic       w_d_sel, w_busy, w_timeout;
  logic [1:0] r_axready_m, r_gnt;
  logic       r_d_sel, r_busy, r_timeout;

  int checks   = 0;
  int failures = 0;
  int beats;

  ax_arbiter #(.IS_WRITE(1'b1), .TIMEOUT_CYC(16), .TO_W(16)) dut_w (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .axvalid_m (axvalid_m),
    .axready_s (axready_s),
    .axready_m (w_axready_m),
    .gnt       (w_gnt),
    .dvalid    (dvalid),
    .dready    (dready),
    .dlast     (dlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .d_sel     (w_d_sel),
    .busy      (w_busy),
    .timeout   (w_timeout)
  );

  ax_arbiter #(.IS_WRITE(1'b0), .TIMEOUT_CYC(0), .TO_W(16)) dut_r (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .axvalid_m (axvalid_m),
    .axready_s (axready_s),
    .axready_m (r_axready_m),
    .gnt       (r_gnt),
    .dvalid    (dvalid),
    .dready    (dready),
    .dlast     (dlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .d_sel     (r_d_sel),
    .busy      (r_busy),
    .timeout   (r_timeout)
  );

  // Free-running 100 MHz clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] axv, input logic axr, input logic dv,
                               input logic dr, input logic dl, input logic bv, input logic br);
    axvalid_m = axv;
    axready_s = axr;
    dvalid    = dv;
    dready    = dr;
    dlast     = dl;
    bvalid    = bv;
    bready    = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #20;

    // Reset state
    checkOutput("rst_w_gnt",     16'(w_gnt), 16'h0);
    checkOutput("rst_w_busy",    16'(w_busy), 16'h0);
    checkOutput("rst_w_dsel",    16'(w_d_sel), 16'h0);
    checkOutput("rst_w_timeout", 16'(w_timeout), 16'h0);
    checkOutput("rst_w_axready", 16'(w_axready_m), 16'h0);
    checkOutput("rst_r_gnt",     16'(r_gnt), 16'h0);

    // Test 1: async reset in the middle of ADDR
    tick();
    ARESETn = 1'b1;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t1_gnt_addr",  16'(w_gnt), 16'h1);
    checkOutput("t1_busy_addr", 16'(w_busy), 16'h1);
    ARESETn = 1'b0;
    #1;
    checkOutput("t1_gnt_async",  16'(w_gnt), 16'h0);
    checkOutput("t1_busy_async", 16'(w_busy), 16'h0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_no_axready", 16'(w_axready_m), 16'h0);

    // Test 2: both valid at reset exit, M0 write of 4 beats, then M1 wins
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ARESETn = 1'b1;
    tick();
    checkOutput("t2_first_gnt", 16'(w_gnt), 16'h1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_axready", 16'(w_axready_m), 16'h1);
    tick();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(2'b10, 1'b0, 1'b1, 1'b1, (b == 3), 1'b1, 1'b1);
      checkOutput("t2_dsel_beat", 16'(w_d_sel), 16'h1);
      tick();
    end
    checkOutput("t2_resp_busy", 16'(w_busy), 16'h1);
    checkOutput("t2_resp_dsel", 16'(w_d_sel), 16'h0);
    checkOutput("t2_resp_gnt",  16'(w_gnt), 16'h1);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("t2_gap_gnt",  16'(w_gnt), 16'h0);
    checkOutput("t2_gap_busy", 16'(w_busy), 16'h0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t2_second_gnt", 16'(w_gnt), 16'h2);

    // Test 3: read instance, M1 AR then 8 R beats with dready toggling
    ARESETn = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ARESETn = 1'b1;
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_gnt", 16'(r_gnt), 16'h2);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_axready", 16'(r_axready_m), 16'h2);
    tick();
    beats = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, c[0], (beats == 7), 1'b0, 1'b0);
      checkOutput("t3_gnt_held", 16'(r_gnt), 16'h2);
      checkOutput("t3_dsel",     16'(r_d_sel), 16'h1);
      tick();
      if (c[0]) beats++;
    end
    checkOutput("t3_end_busy", 16'(r_busy), 16'h0);
    checkOutput("t3_end_gnt",  16'(r_gnt), 16'h0);

    // Test 4: slave holds off AW for 5 cycles
    ARESETn = 1'b0;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ARESETn = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4_axready_low", 16'(w_axready_m), 16'h0);
      checkOutput("t4_gnt_hold",    16'(w_gnt), 16'h1);
      checkOutput("t4_in_addr",     16'({w_busy, w_d_sel}), 16'h2);
      tick();
    end
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_axready_up", 16'(w_axready_m), 16'h1);
    tick();
    checkOutput("t4_data", 16'(w_d_sel), 16'h1);

    // Test 5: last W beat accepted, slave never answers B -> watchdog
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 16; k++) begin
      tick();
      checkOutput("t5_no_timeout", 16'(w_timeout), 16'h0);
      checkOutput("t5_still_busy", 16'(w_busy), 16'h1);
    end
    tick();
    checkOutput("t5_timeout", 16'(w_timeout), 16'h1);
    checkOutput("t5_idle",    16'(w_busy), 16'h0);
    checkOutput("t5_gnt",     16'(w_gnt), 16'h0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_pulse_end", 16'(w_timeout), 16'h0);
    checkOutput("t5_prio_flip", 16'(w_gnt), 16'h2);

    // Test 6: continuous requests from both masters, 10 transactions
    ARESETn = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    ARESETn = 1'b1;
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 8 && w_gnt == 2'b00; k++) tick();
      checkOutput("t6_grant_seen", 16'(w_gnt != 2'b00), 16'h1);
      checkOutput("t6_alternate",  16'(w_gnt), (t % 2 == 0) ? 16'h1 : 16'h2);
      for (int k = 0; k < 8 && w_gnt != 2'b00; k++) begin
        checkOutput("t6_not_both", 16'(w_gnt == 2'b11), 16'h0);
        tick();
      end
      checkOutput("t6_release", 16'(w_gnt), 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
